// File: rtl/cdctl_spi_master.sv
// SPI mode-0 master for cdctl register access: one header byte {write, addr}
// followed by cmd_len data bytes, plus a synchronised interrupt input.
module cdctl_spi_master #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_len,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       done,
   output logic       busy,
   output logic       nss,
   output logic       sck,
   output logic       sdo,
   input  logic       sdi,
   input  logic       int_n,
   output logic       irq
);

   localparam int unsigned DIV_W = 8;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_LOAD, S_HOLD, S_GAP
   } state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       byte_q, byte_d;
   logic [7:0]       tx_q, tx_d;
   logic [7:0]       rx_q, rx_d;
   logic [7:0]       rd_data_q, rd_data_d;
   logic             write_q, write_d;
   logic             hdr_q, hdr_d;
   logic             taken_q, taken_d;
   logic             pend_q, pend_d;
   logic             nss_q, nss_d;
   logic             sck_q, sck_d;
   logic             sdo_q, sdo_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             busy_q, busy_d;
   logic             wr_ready_q, wr_ready_d;
   logic             rd_valid_q, rd_valid_d;
   logic             done_q, done_d;
   logic             int_s1_q, int_s2_q, irq_q;

   // Next-state and output logic for the transaction sequencer
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      write_d     = write_q;
      hdr_d       = hdr_q;
      taken_d     = taken_q;
      pend_d      = 1'b0;
      nss_d       = nss_q;
      sck_d       = sck_q;
      sdo_d       = sdo_q;
      wr_ready_d  = 1'b0;
      done_d      = 1'b0;
      // a read byte completed on the previous rising sck edge is published now
      rd_valid_d  = pend_q;
      rd_data_d   = pend_q ? rx_q : rd_data_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d = S_SETUP;
               nss_d   = 1'b0;
               tx_d    = {cmd_write, cmd_addr};
               sdo_d   = cmd_write;
               write_d = cmd_write;
               byte_d  = cmd_len;
               hdr_d   = 1'b1;
               div_d   = DIV_LAST;
            end
         end
         S_SETUP: begin
            if (div_q != '0) begin
               div_d = div_q - DIV_W'(1);
            end else begin
               state_d = S_SHIFT;
               sck_d   = 1'b1;
               bit_d   = 3'd7;
               rx_d    = {rx_q[6:0], sdi};
               div_d   = DIV_LAST;
            end
         end
         S_SHIFT: begin
            if (div_q != '0) begin
               div_d = div_q - DIV_W'(1);
            end else begin
               div_d = DIV_LAST;
               if (sck_q) begin
                  // falling edge: present next bit, or spend the low phase in LOAD
                  sck_d = 1'b0;
                  if (bit_q != 3'd0) begin
                     sdo_d = tx_q[bit_q - 3'd1];
                  end else if (byte_q != 8'd0) begin
                     state_d = S_LOAD;
                     byte_d  = byte_q - 8'd1;
                     taken_d = 1'b0;
                     hdr_d   = 1'b0;
                  end
               end else if (bit_q == 3'd0) begin
                  state_d = S_HOLD;
               end else begin
                  // rising edge: sample sdi
                  bit_d = bit_q - 3'd1;
                  sck_d = 1'b1;
                  rx_d  = {rx_q[6:0], sdi};
                  if (bit_q == 3'd1 && !hdr_q && !write_q) begin
                     pend_d = 1'b1;
                  end
               end
            end
         end
         S_LOAD: begin
            if (div_q != '0) begin
               div_d = div_q - DIV_W'(1);
            end
            if (!taken_q) begin
               if (!write_q) begin
                  tx_d    = 8'h00;
                  sdo_d   = 1'b0;
                  taken_d = 1'b1;
               end else if (wr_valid) begin
                  tx_d       = wr_data;
                  sdo_d      = wr_data[7];
                  wr_ready_d = 1'b1;
                  taken_d    = 1'b1;
               end
            end else if (div_q == '0) begin
               state_d = S_SHIFT;
               sck_d   = 1'b1;
               bit_d   = 3'd7;
               rx_d    = {rx_q[6:0], sdi};
               div_d   = DIV_LAST;
            end
         end
         S_HOLD: begin
            if (div_q != '0) begin
               div_d = div_q - DIV_W'(1);
            end else begin
               state_d = S_GAP;
               nss_d   = 1'b1;
               sdo_d   = 1'b0;
               done_d  = 1'b1;
               div_d   = DIV_LAST;
            end
         end
         S_GAP: begin
            if (div_q != '0) begin
               div_d = div_q - DIV_W'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         bit_q       <= 3'd0;
         byte_q      <= 8'd0;
         tx_q        <= 8'd0;
         rx_q        <= 8'd0;
         rd_data_q   <= 8'd0;
         write_q     <= 1'b0;
         hdr_q       <= 1'b0;
         taken_q     <= 1'b0;
         pend_q      <= 1'b0;
         nss_q       <= 1'b1;
         sck_q       <= 1'b0;
         sdo_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rd_data_q   <= rd_data_d;
         write_q     <= write_d;
         hdr_q       <= hdr_d;
         taken_q     <= taken_d;
         pend_q      <= pend_d;
         nss_q       <= nss_d;
         sck_q       <= sck_d;
         sdo_q       <= sdo_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
         wr_ready_q  <= wr_ready_d;
         rd_valid_q  <= rd_valid_d;
         done_q      <= done_d;
      end
   end

   // Two-flop synchroniser for int_n, inverted into a registered irq
   always_ff @(posedge clk) begin
      if (reset) begin
         int_s1_q <= 1'b1;
         int_s2_q <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         int_s1_q <= int_n;
         int_s2_q <= int_s1_q;
         irq_q    <= ~int_s2_q;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign wr_ready  = wr_ready_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign done      = done_q;
   assign nss       = nss_q;
   assign sck       = sck_q;
   assign sdo       = sdo_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_cdctl_spi_master.sv
// Bench for cdctl_spi_master: a slave/bus monitor collects what went over the
// wire and a transaction-level model predicts it from the command alone.
module tb_cdctl_spi_master;

   localparam int unsigned CLK_DIV = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [6:0] cmd_addr = 7'd0;
   logic [7:0] cmd_len = 8'd0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       done;
   logic       busy;
   logic       nss;
   logic       sck;
   logic       sdo;
   logic       sdi = 1'b0;
   logic       int_n = 1'b1;
   logic       irq;

   cdctl_spi_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
      .nss(nss), .sck(sck), .sdo(sdo), .sdi(sdi),
      .int_n(int_n), .irq(irq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Stimulus tables owned by the test sequence
   logic [7:0] wq [0:255];
   logic [7:0] slave_tx [0:256];
   bit         wr_en = 1'b0;
   bit         stall_req = 1'b0;

   // Observations owned by the monitor
   int         cyc = 0, last_rise = 0;
   int         rises = 0, wr_cnt = 0, done_cnt = 0;
   int         win_cur = 0, win_last = 0;
   int         rdv_bad = 0, sdo_bad = 0, stall_bad = 0, stall_arms = 0;
   int         acc_n = 0, s_byte = 0, s_bit = 7, w_idx = 0, stall_left = 0;
   logic [7:0] acc = 8'd0;
   logic [7:0] mosi_q [$];
   logic [7:0] rd_q [$];
   bit         nss_prev = 1'b1, sck_prev = 1'b0, stall_hold = 1'b0, stall_used = 1'b0;

   // Slave model, write-data source and bus monitor, all away from the active edge
   always @(negedge clk) begin
      cyc++;
      if (!nss && nss_prev) begin
         win_cur = 0; acc_n = 0; s_byte = 0; s_bit = 7; w_idx = 0; stall_used = 1'b0;
         sdi = slave_tx[0][7];
      end
      if (!nss) win_cur++;
      if (nss && !nss_prev) win_last = win_cur;
      if (sck && !sck_prev) begin
         rises++;
         last_rise = cyc;
         acc = {acc[6:0], sdo};
         acc_n++;
         if (acc_n == 8) begin
            mosi_q.push_back(acc);
            acc_n = 0;
         end
      end
      if (!sck && sck_prev) begin
         if (s_bit == 0) begin
            s_byte++;
            s_bit = 7;
         end else begin
            s_bit--;
         end
         sdi = slave_tx[s_byte][s_bit];
         if (stall_hold && stall_left == 0 && acc_n == 0) begin
            stall_left = 10;
            stall_arms++;
         end
      end
      if (wr_ready) begin
         wr_cnt++;
         w_idx++;
         if (stall_req && !stall_used) begin
            stall_hold = 1'b1;
            stall_used = 1'b1;
         end
      end
      if (stall_left > 0) begin
         if (sck || nss) stall_bad++;
         stall_left--;
         if (stall_left == 0) stall_hold = 1'b0;
      end
      if (done) done_cnt++;
      if (rd_valid) begin
         rd_q.push_back(rd_data);
         if (cyc != last_rise + 1 || acc_n != 0) rdv_bad++;
      end
      if (nss && sdo) sdo_bad++;
      wr_valid = wr_en && !stall_hold;
      wr_data  = wq[w_idx];
      nss_prev = nss;
      sck_prev = sck;
   end

   task automatic fill_random(input int len);
      for (int i = 0; i < 256; i++) wq[i] = 8'($urandom);
      for (int i = 0; i <= 256; i++) slave_tx[i] = 8'($urandom);
      if (len < 0) wq[0] = 8'h00;
   endtask

   task automatic issue(input bit w, input logic [6:0] a, input int len);
      int n;
      n = 0;
      wr_en = w;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 8'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = 7'($urandom); cmd_len = 8'($urandom);
      chk("accept_nss", 32'(nss), 32'd0);
      chk("accept_busy", 32'({busy, cmd_ready}), 32'h2);
   endtask

   task automatic wait_idle(input string tag, input int lim);
      int n;
      n = 0;
      while (!done && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done), 32'd1);
      while (!cmd_ready && n < lim + 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   // One complete transaction compared against the transaction-level expectation
   task automatic run_cmd(input bit w, input logic [6:0] a, input int len, input bit stall);
      int r0, wr0, d0, rd0, mq0, s0;
      logic [7:0] exp_b;
      r0 = rises; wr0 = wr_cnt; d0 = done_cnt; rd0 = rd_q.size(); mq0 = mosi_q.size();
      s0 = stall_arms;
      stall_req = stall;
      issue(w, a, len);
      wait_idle("done_seen", 40 * (len + 2) * int'(CLK_DIV) + 200);
      stall_req = 1'b0;
      chk("sck_pulses", 32'(rises - r0), 32'(8 * (len + 1)));
      chk("wr_ready_cnt", 32'(wr_cnt - wr0), w ? 32'(len) : 32'd0);
      chk("done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("rd_valid_cnt", 32'(rd_q.size() - rd0), w ? 32'd0 : 32'(len));
      chk("mosi_bytes", 32'(mosi_q.size() - mq0), 32'(len + 1));
      for (int i = 0; i <= len && mq0 + i < mosi_q.size(); i++) begin
         exp_b = (i == 0) ? {w, a} : (w ? wq[i-1] : 8'h00);
         chk($sformatf("mosi[%0d]", i), 32'(mosi_q[mq0 + i]), 32'(exp_b));
      end
      if (!w) begin
         for (int i = 0; i < len && rd0 + i < rd_q.size(); i++)
            chk($sformatf("rd_data[%0d]", i), 32'(rd_q[rd0 + i]), 32'(slave_tx[i+1]));
      end
      if (stall) chk("stall_happened", 32'(stall_arms - s0), 32'd1);
      else       chk("nss_window", 32'(win_last), 32'((2 + 16 * (len + 1)) * int'(CLK_DIV)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, gap, rdy, d0, r0, rd0;
      logic [6:0] a;
      fill_random(0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset values
      chk("rst_nss", 32'(nss), 32'd1);
      chk("rst_sck_sdo", 32'({sck, sdo}), 32'd0);
      chk("rst_ready_busy", 32'({cmd_ready, busy}), 32'h2);
      chk("rst_strobes", 32'({wr_ready, rd_valid, done}), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);

      // directed: write 0x05 len 1 data 0xA5
      fill_random(0);
      wq[0] = 8'hA5;
      run_cmd(1'b1, 7'h05, 1, 1'b0);

      // directed: read 0x06 len 2, slave returns 0x3C, 0xC3
      fill_random(0);
      slave_tx[1] = 8'h3C;
      slave_tx[2] = 8'hC3;
      run_cmd(1'b0, 7'h06, 2, 1'b0);

      // directed: write len 2 with wr_valid stalled before the second byte
      fill_random(0);
      run_cmd(1'b1, 7'h11, 2, 1'b1);

      // directed: header only
      fill_random(0);
      run_cmd(1'b1, 7'h7F, 0, 1'b0);

      // randomized transactions
      for (int t = 0; t < 8; t++) begin
         fill_random(0);
         run_cmd(1'($urandom), 7'($urandom), int'($urandom_range(0, 4)), 1'b0);
      end

      // reset at the 5th sck rise of a read
      fill_random(0);
      d0 = done_cnt; r0 = rises; rd0 = rd_q.size();
      issue(1'b0, 7'h22, 2);
      n = 0;
      while (rises - r0 < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached", 32'(rises - r0), 32'd5);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_nss", 32'(nss), 32'd1);
      chk("abort_sck", 32'(sck), 32'd0);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_no_rdv", 32'(rd_q.size() - rd0), 32'd0);
      fill_random(0);
      run_cmd(1'b0, 7'h33, 1, 1'b0);

      // cmd_valid held through GAP: next command only starts from IDLE
      fill_random(0);
      a = 7'($urandom);
      d0 = done_cnt; r0 = rises;
      wr_en = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 8'd0;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("hold_done1", 32'(done), 32'd1);
      gap = 0; rdy = 0; n = 0;
      while (nss && n < 50) begin
         gap++;
         if (cmd_ready) rdy++;
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      chk("gap_cycles", 32'(gap), 32'(CLK_DIV + 1));
      chk("ready_in_gap", 32'(rdy), 32'd1);
      wait_idle("hold_done2", 300);
      chk("hold_done_cnt", 32'(done_cnt - d0), 32'd2);
      chk("hold_pulses", 32'(rises - r0), 32'd16);

      // interrupt synchroniser
      int_n = 1'b0;
      n = 0;
      while (!irq && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk("irq_set_within_3", 32'(irq && n <= 3), 32'd1);
      int_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("irq_clear", 32'(irq), 32'd0);

      // invariants gathered across the whole run
      chk("rd_valid_timing", 32'(rdv_bad), 32'd0);
      chk("sdo_low_when_idle", 32'(sdo_bad), 32'd0);
      chk("stall_pins", 32'(stall_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdctl_spi_master.md
CDCTL_SPI_MASTER -- requirements
Module: cdctl_spi_master

Interface
REQ-001 Parameter: CLK_DIV, default 2; SCK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  transaction request.
REQ-005 cmd_ready  output  1  high only in IDLE; a transaction is accepted when cmd_valid&&cmd_ready.
REQ-006 cmd_write  input  1  1 = register write, 0 = register read.
REQ-007 cmd_addr  input  7  cdctl register address.
REQ-008 cmd_len  input  8  number of data bytes after the header byte, 0..255; 0 = header only.
REQ-009 wr_data  input  8  next write byte.
REQ-010 wr_valid  input  1  wr_data is valid.
REQ-011 wr_ready  output  1  one-cycle pulse when wr_data is consumed.
REQ-012 rd_data  output  8  received byte; held until the next update.
REQ-013 rd_valid  output  1  one-cycle pulse with each read byte.
REQ-014 done  output  1  one-cycle pulse when nss deasserts at transaction end.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 nss  output  1  active-low slave select.
REQ-017 sck  output  1  SPI clock, mode 0 (idles low).
REQ-018 sdo  output  1  master-out data, MSB first.
REQ-019 sdi  input  1  master-in data, sampled on the sck rising edge.
REQ-020 int_n  input  1  cdctl interrupt, asynchronous to clk.
REQ-021 irq  output  1  int_n synchronised through 2 flops and inverted.

Function
REQ-022 Header byte: {cmd_write, cmd_addr}; cmd_write, cmd_addr and cmd_len are latched on acceptance.
REQ-023 States: IDLE, SETUP, SHIFT, LOAD, HOLD, GAP.
REQ-024 IDLE->SETUP on accept: nss drops the next cycle, and sdo = header bit 7.
REQ-025 SETUP lasts CLK_DIV cycles, then goes to SHIFT.
REQ-026 SHIFT, per bit: sck high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-027 SHIFT, sdi: sampled into a shift register on the cycle sck rises.
REQ-028 SHIFT, sdo: the next bit is presented on the cycle sck falls.
REQ-029 A byte therefore spans 16*CLK_DIV cycles.
REQ-030 After bit 0 of any byte, if bytes remain, go to LOAD; otherwise go to HOLD.
REQ-031 LOAD, write: if wr_valid=1, take wr_data, pulse wr_ready, set sdo = bit 7 and return to SHIFT the next cycle.
REQ-032 LOAD, write stall: if wr_valid=0, stay in LOAD with sck low, nss low and no timeout.
REQ-033 LOAD, read: sdo = 0, then return to SHIFT the next cycle; the master sends 0x00 for every read byte.
REQ-034 rd_valid pulses exactly one cycle after the 8th rising sck edge of each read data byte, with rd_data = the received byte.
REQ-035 The byte received during the header is discarded, and no rd_valid is produced during write transactions.
REQ-036 HOLD lasts CLK_DIV cycles with sck low; then nss rises, done pulses and the block enters GAP.
REQ-037 GAP lasts CLK_DIV cycles with nss high, then goes to IDLE; cmd_ready is low throughout GAP.
REQ-038 cmd_valid while busy is ignored and not queued.
REQ-039 Changes to wr_valid or cmd_* outside their sampling points have no effect.
REQ-040 Counters: bit counter 3 bits, byte counter 8 bits counting down from cmd_len, divider counter 8 bits; no wrap beyond these ranges.
REQ-041 sdo is 0 whenever nss is high.

Reset
REQ-042 reset has priority over every other input and takes effect on the clk edge where it is sampled high.
REQ-043 Reset values: state = IDLE, nss = 1, sck = 0, sdo = 0, cmd_ready = 1 the cycle after release, busy = 0.
REQ-044 Reset values (strobes and data): wr_ready = 0, rd_valid = 0, done = 0, rd_data = 0x00.
REQ-045 Reset values (irq path): irq = 0, both int_n synchroniser flops = 1.
REQ-046 Reset mid-transaction: aborts immediately with nss = 1 next cycle; no done pulse and no further wr_ready or rd_valid.

Verification
REQ-047 CLK_DIV=2, write addr 0x05, len 1, wr_data 0xA5 -> sdo carries 0x85 then 0xA5; exactly 16 sck pulses; one wr_ready; done pulses once; the nss-low window is 2+64+2 cycles.
REQ-048 Read addr 0x06, len 2, slave model returns 0x3C then 0xC3 -> sdo carries 0x06 then 0x00,0x00; two rd_valid pulses with 0x3C and 0xC3; no wr_ready.
REQ-049 Write len 2 with wr_valid held low for 10 cycles before the second byte -> sck stays low and nss stays low during the stall; the transfer resumes and completes correctly.
REQ-050 len 0, write addr 0x7F -> only header 0xFF is sent (8 sck pulses); no wr_ready; done pulses once.
REQ-051 Reset asserted at the 5th sck rise of a read -> nss=1 and sck=0 the next cycle; no rd_valid or done; a following command completes normally.
REQ-052 int_n driven low -> irq=1 within 3 clk cycles; cmd_valid held high through GAP -> the next transaction starts only once back in IDLE.
